// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-search controller and its decryption sub-core.
package rc4_pkg;

    localparam int unsigned KEY_W   = 24;
    localparam int unsigned MSG_LEN = 32;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        LAUNCH,
        WAIT,
        CHECK,
        DONE
    } state_e;

endpackage

// File: rtl/attempt_watchdog.sv
// Clearable saturating cycle counter; tc_o flags the TIMEOUT_CYCLES-th enabled cycle since clear.
module attempt_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 16384
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned   CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q >= LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_search_ctrl.sv
// Walks KEY_START..KEY_END in KEY_STEP strides, running one RC4 sub-core attempt per candidate
// and latching the first key the core reports as found.
module key_search_ctrl
    import rc4_pkg::*;
#(
    parameter logic [KEY_W-1:0] KEY_START      = 24'h000000,
    parameter logic [KEY_W-1:0] KEY_END        = 24'h3FFFFF,
    parameter logic [KEY_W-1:0] KEY_STEP       = 24'd1,
    parameter int unsigned      RESET_CYCLES   = 2,
    parameter int unsigned      TIMEOUT_CYCLES = 16384
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             go,
    input  logic             stop,
    output logic             core_reset,
    output logic             core_start,
    output logic [KEY_W-1:0] core_key,
    input  logic             core_start_done,
    input  logic             core_finish,
    input  logic             core_keyfound,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [KEY_W-1:0] found_key,
    output logic             timeout_err,
    output logic [KEY_W-1:0] attempts
);

    localparam logic [3:0] RST_LAST = 4'(RESET_CYCLES - 1);

    state_e           state_q, state_d;
    logic             core_reset_q, core_reset_d;
    logic             core_start_q, core_start_d;
    logic [KEY_W-1:0] core_key_q, core_key_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic [KEY_W-1:0] found_key_q, found_key_d;
    logic             timeout_err_q, timeout_err_d;
    logic [KEY_W-1:0] attempts_q, attempts_d;
    logic [3:0]       rst_cnt_q, rst_cnt_d;
    logic             keyfound_q, keyfound_d;

    logic             wd_clr, wd_en, wd_tc;
    logic             to_done;
    logic [KEY_W:0]   next_key;

    // Carry into bit KEY_W means the stride ran past the top of the key space.
    assign next_key = {1'b0, core_key_q} + {1'b0, KEY_STEP};

    attempt_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i (CLOCK_50),
        .rst_i (reset),
        .clr_i (wd_clr),
        .en_i  (wd_en),
        .tc_o  (wd_tc)
    );

    always_comb begin
        state_d       = state_q;
        core_reset_d  = core_reset_q;
        core_start_d  = core_start_q;
        core_key_d    = core_key_q;
        busy_d        = busy_q;
        done_d        = done_q;
        found_d       = found_q;
        found_key_d   = found_key_q;
        timeout_err_d = timeout_err_q;
        attempts_d    = attempts_q;
        rst_cnt_d     = rst_cnt_q;
        keyfound_d    = keyfound_q;
        wd_clr        = 1'b0;
        wd_en         = 1'b0;
        to_done       = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    state_d       = RST;
                    core_key_d    = KEY_START;
                    attempts_d    = '0;
                    found_d       = 1'b0;
                    timeout_err_d = 1'b0;
                    done_d        = 1'b0;
                    busy_d        = 1'b1;
                    core_reset_d  = 1'b1;
                    rst_cnt_d     = '0;
                end
            end
            RST: begin
                if (stop) begin
                    to_done = 1'b1;
                end else if (rst_cnt_q == RST_LAST) begin
                    state_d      = LAUNCH;
                    core_reset_d = 1'b0;
                    core_start_d = 1'b1;
                    wd_clr       = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + 4'd1;
                end
            end
            LAUNCH: begin
                wd_en = 1'b1;
                if (stop) begin
                    to_done = 1'b1;
                end else if (core_start_done) begin
                    state_d      = WAIT;
                    core_start_d = 1'b0;
                    wd_clr       = 1'b1;
                end else if (wd_tc) begin
                    timeout_err_d = 1'b1;
                    to_done       = 1'b1;
                end
            end
            WAIT: begin
                wd_en = 1'b1;
                if (stop) begin
                    to_done = 1'b1;
                end else if (core_finish) begin
                    state_d    = CHECK;
                    keyfound_d = core_keyfound;
                end else if (wd_tc) begin
                    timeout_err_d = 1'b1;
                    to_done       = 1'b1;
                end
            end
            CHECK: begin
                attempts_d = attempts_q + 24'd1;
                if (keyfound_q) begin
                    found_d     = 1'b1;
                    found_key_d = core_key_q;
                    to_done     = 1'b1;
                end else if (stop || (next_key > {1'b0, KEY_END})) begin
                    to_done = 1'b1;
                end else begin
                    state_d      = RST;
                    core_key_d   = next_key[KEY_W-1:0];
                    core_reset_d = 1'b1;
                    rst_cnt_d    = '0;
                end
            end
            default: begin
                to_done = 1'b1;
            end
        endcase

        if (to_done) begin
            state_d      = DONE;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            core_reset_d = 1'b1;
            core_start_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= IDLE;
            core_reset_q  <= 1'b1;
            core_start_q  <= 1'b0;
            core_key_q    <= KEY_START;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            found_key_q   <= '0;
            timeout_err_q <= 1'b0;
            attempts_q    <= '0;
            rst_cnt_q     <= '0;
            keyfound_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            core_reset_q  <= core_reset_d;
            core_start_q  <= core_start_d;
            core_key_q    <= core_key_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            found_q       <= found_d;
            found_key_q   <= found_key_d;
            timeout_err_q <= timeout_err_d;
            attempts_q    <= attempts_d;
            rst_cnt_q     <= rst_cnt_d;
            keyfound_q    <= keyfound_d;
        end
    end

    assign core_reset  = core_reset_q;
    assign core_start  = core_start_q;
    assign core_key    = core_key_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign found       = found_q;
    assign found_key   = found_key_q;
    assign timeout_err = timeout_err_q;
    assign attempts    = attempts_q;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Bench for key_search_ctrl: three controllers with different key ranges, each driving a behavioural sub-core.
module tb_key_search_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [23:0] KS0 = 24'h000000, KE0 = 24'h3FFFFF, ST0 = 24'd1;
    localparam logic [23:0] KS1 = 24'h000000, KE1 = 24'h000003, ST1 = 24'd1;
    localparam logic [23:0] KS2 = 24'hFFFFFE, KE2 = 24'hFFFFFF, ST2 = 24'd4;

    logic        rst = 1'b1;
    logic        go [3];
    logic        stop [3];
    logic        c_reset [3];
    logic        c_start [3];
    logic [23:0] c_key [3];
    logic        sd [3];
    logic        fin [3];
    logic        kf [3];
    logic        busy [3];
    logic        done [3];
    logic        found [3];
    logic        terr [3];
    logic [23:0] fkey [3];
    logic [23:0] att [3];

    int          lat [3]    = '{10, 10, 10};
    logic [23:0] target [3] = '{24'd0, 24'd0, 24'd0};
    bit          tgt_en [3] = '{0, 0, 0};
    bit          nofin [3]  = '{0, 0, 0};
    bit          given [3]  = '{0, 0, 0};
    bit          run [3]    = '{0, 0, 0};
    int          cnt [3]    = '{0, 0, 0};
    logic [23:0] key_log [3][256];
    int          key_n [3]  = '{0, 0, 0};

    int checks = 0;
    int errors = 0;

    key_search_ctrl #(.KEY_START(KS0), .KEY_END(KE0), .KEY_STEP(ST0), .RESET_CYCLES(2), .TIMEOUT_CYCLES(100)) dut_a (
        .CLOCK_50(clk), .reset(rst), .go(go[0]), .stop(stop[0]),
        .core_reset(c_reset[0]), .core_start(c_start[0]), .core_key(c_key[0]),
        .core_start_done(sd[0]), .core_finish(fin[0]), .core_keyfound(kf[0]),
        .busy(busy[0]), .done(done[0]), .found(found[0]), .found_key(fkey[0]),
        .timeout_err(terr[0]), .attempts(att[0]));

    key_search_ctrl #(.KEY_START(KS1), .KEY_END(KE1), .KEY_STEP(ST1), .RESET_CYCLES(3), .TIMEOUT_CYCLES(100)) dut_b (
        .CLOCK_50(clk), .reset(rst), .go(go[1]), .stop(stop[1]),
        .core_reset(c_reset[1]), .core_start(c_start[1]), .core_key(c_key[1]),
        .core_start_done(sd[1]), .core_finish(fin[1]), .core_keyfound(kf[1]),
        .busy(busy[1]), .done(done[1]), .found(found[1]), .found_key(fkey[1]),
        .timeout_err(terr[1]), .attempts(att[1]));

    key_search_ctrl #(.KEY_START(KS2), .KEY_END(KE2), .KEY_STEP(ST2), .RESET_CYCLES(2), .TIMEOUT_CYCLES(100)) dut_c (
        .CLOCK_50(clk), .reset(rst), .go(go[2]), .stop(stop[2]),
        .core_reset(c_reset[2]), .core_start(c_start[2]), .core_key(c_key[2]),
        .core_start_done(sd[2]), .core_finish(fin[2]), .core_keyfound(kf[2]),
        .busy(busy[2]), .done(done[2]), .found(found[2]), .found_key(fkey[2]),
        .timeout_err(terr[2]), .attempts(att[2]));

    // Sub-core model: start_done one cycle after start, finish roughly lat cycles later.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (c_reset[i] === 1'b1) begin
                sd[i] <= 1'b0; fin[i] <= 1'b0; kf[i] <= 1'b0;
                given[i] <= 1'b0; run[i] <= 1'b0; cnt[i] <= 0;
            end else begin
                sd[i]  <= 1'b0;
                fin[i] <= 1'b0;
                if (c_start[i] === 1'b1 && !given[i]) begin
                    sd[i] <= 1'b1; given[i] <= 1'b1; run[i] <= 1'b1;
                    cnt[i] <= lat[i] + int'($urandom_range(0, 3));
                    key_log[i][key_n[i] % 256] <= c_key[i];
                    key_n[i] <= key_n[i] + 1;
                end else if (run[i] && !sd[i]) begin
                    if (cnt[i] <= 1) begin
                        if (!nofin[i]) begin
                            fin[i] <= 1'b1;
                            kf[i]  <= tgt_en[i] && (c_key[i] == target[i]);
                            run[i] <= 1'b0;
                        end
                    end else begin
                        cnt[i] <= cnt[i] - 1;
                    end
                end
            end
        end
    end

    // Reference: walk the candidate list as integers until hit or past the end.
    function automatic void ref_search(input longint s, input longint e, input longint st,
                                       input longint tgt, input bit en,
                                       output int n, output longint last);
        longint k = s;
        bit     fin_s = 1'b0;
        n = 0;
        last = s;
        while (!fin_s) begin
            n++;
            last = k;
            if (en && k == tgt) fin_s = 1'b1;
            else begin
                k += st;
                if (k > e) fin_s = 1'b1;
            end
        end
    endfunction

    task automatic test_reset();
        logic [23:0] ks [3] = '{KS0, KS1, KS2};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({c_reset[i], c_start[i], busy[i], done[i], found[i], terr[i]} !== 6'b100000) begin
                errors++;
                $display("FAIL reset_flags[%0d]: got %b expected 100000", i,
                         {c_reset[i], c_start[i], busy[i], done[i], found[i], terr[i]});
            end
            checks++;
            if (c_key[i] !== ks[i]) begin
                errors++; $display("FAIL reset_key[%0d]: got %h expected %h", i, c_key[i], ks[i]);
            end
            checks++;
            if (att[i] !== 24'd0 || fkey[i] !== 24'd0) begin
                errors++; $display("FAIL reset_counts[%0d]: attempts %h found_key %h expected 0", i, att[i], fkey[i]);
            end
        end
    endtask

    task automatic test_found();
        int n; longint last; int base; bit ok;
        for (int r = 0; r < 3; r++) begin
            target[0] = (r == 0) ? 24'h000005 : 24'($urandom_range(0, 12));
            tgt_en[0] = 1'b1;
            nofin[0]  = 1'b0;
            lat[0]    = (r == 0) ? 50 : int'($urandom_range(3, 20));
            base      = key_n[0];
            go[0] = 1'b1; @(negedge clk); go[0] = 1'b0;
            ok = 1'b0;
            for (int c = 0; c < 5000; c++) begin
                @(negedge clk);
                if (done[0] === 1'b1) begin ok = 1'b1; break; end
            end
            checks++;
            if (!ok) begin errors++; $display("FAIL found_wait: done never rose, target %h", target[0]); end
            ref_search(longint'(KS0), longint'(KE0), longint'(ST0), longint'(target[0]), 1'b1, n, last);
            checks++;
            if (att[0] !== 24'(n)) begin
                errors++; $display("FAIL found_attempts: got %0d expected %0d", att[0], n);
            end
            checks++;
            if (found[0] !== 1'b1 || fkey[0] !== target[0] || busy[0] !== 1'b0) begin
                errors++; $display("FAIL found_result: found %b key %h busy %b expected 1 %h 0",
                                   found[0], fkey[0], busy[0], target[0]);
            end
            checks++;
            if (key_n[0] - base != n) begin
                errors++; $display("FAIL found_launches: got %0d expected %0d", key_n[0] - base, n);
            end
            for (int j = 0; j < n; j++) begin
                checks++;
                if (key_log[0][(base + j) % 256] !== 24'(longint'(KS0) + j * longint'(ST0))) begin
                    errors++; $display("FAIL found_keyseq[%0d]: got %h expected %h", j,
                                       key_log[0][(base + j) % 256], 24'(longint'(KS0) + j * longint'(ST0)));
                end
            end
        end
    endtask

    task automatic test_exhaust();
        int n; longint last; int base; bit ok;
        tgt_en[1] = 1'b0;
        lat[1]    = int'($urandom_range(3, 15));
        base      = key_n[1];
        go[1] = 1'b1; stop[1] = 1'b1;
        @(negedge clk);
        go[1] = 1'b0; stop[1] = 1'b0;
        checks++;
        if (busy[1] !== 1'b1 || done[1] !== 1'b0) begin
            errors++; $display("FAIL go_stop_idle: busy %b done %b expected 1 0", busy[1], done[1]);
        end
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (done[1] === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL exhaust_wait: done never rose"); end
        ref_search(longint'(KS1), longint'(KE1), longint'(ST1), 0, 1'b0, n, last);
        checks++;
        if (att[1] !== 24'(n) || found[1] !== 1'b0) begin
            errors++; $display("FAIL exhaust_result: attempts %0d found %b expected %0d 0", att[1], found[1], n);
        end
        checks++;
        if (c_key[1] !== 24'(last) || c_reset[1] !== 1'b1 || busy[1] !== 1'b0) begin
            errors++; $display("FAIL exhaust_outputs: key %h core_reset %b busy %b expected %h 1 0",
                               c_key[1], c_reset[1], busy[1], 24'(last));
        end
        checks++;
        if (key_n[1] - base != n) begin
            errors++; $display("FAIL exhaust_launches: got %0d expected %0d", key_n[1] - base, n);
        end
    endtask

    task automatic test_overflow();
        int n; longint last; bit ok;
        tgt_en[2] = 1'b0;
        lat[2]    = 5;
        go[2] = 1'b1; @(negedge clk); go[2] = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (done[2] === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL overflow_wait: done never rose"); end
        ref_search(longint'(KS2), longint'(KE2), longint'(ST2), 0, 1'b0, n, last);
        checks++;
        if (att[2] !== 24'(n) || found[2] !== 1'b0 || c_key[2] !== 24'(last)) begin
            errors++; $display("FAIL overflow_result: attempts %0d found %b key %h expected %0d 0 %h",
                               att[2], found[2], c_key[2], n, 24'(last));
        end
    endtask

    task automatic test_stop();
        int starts = 0; logic prev = 1'b0; bit ok = 1'b0;
        tgt_en[0] = 1'b0; nofin[0] = 1'b0; lat[0] = 40;
        go[0] = 1'b1; @(negedge clk); go[0] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c_start[0] === 1'b1 && !prev) starts++;
            prev = c_start[0];
            if (starts == 3 && c_start[0] === 1'b0) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL stop_wait: third attempt never reached WAIT"); end
        stop[0] = 1'b1; @(negedge clk); stop[0] = 1'b0;
        checks++;
        if ({done[0], found[0], c_start[0], c_reset[0], busy[0]} !== 5'b10010) begin
            errors++; $display("FAIL stop_flags: done,found,start,reset,busy %b expected 10010",
                               {done[0], found[0], c_start[0], c_reset[0], busy[0]});
        end
        checks++;
        if (att[0] !== 24'd2) begin errors++; $display("FAIL stop_attempts: got %0d expected 2", att[0]); end
    endtask

    task automatic test_stop_check();
        bit ok = 1'b0;
        tgt_en[0] = 1'b1; target[0] = 24'd1; lat[0] = 5;
        go[0] = 1'b1; @(negedge clk); go[0] = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (fin[0] === 1'b1 && kf[0] === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL stopchk_wait: keyfound finish never seen"); end
        @(negedge clk);
        stop[0] = 1'b1; @(negedge clk); stop[0] = 1'b0;
        checks++;
        if (found[0] !== 1'b1 || done[0] !== 1'b1 || fkey[0] !== 24'd1 || att[0] !== 24'd2) begin
            errors++; $display("FAIL stopchk_result: found %b done %b key %h attempts %0d expected 1 1 000001 2",
                               found[0], done[0], fkey[0], att[0]);
        end
    endtask

    task automatic test_timeout();
        bit ok = 1'b0; int waitc = 0;
        nofin[0] = 1'b1; tgt_en[0] = 1'b0; lat[0] = 5;
        go[0] = 1'b1; @(negedge clk); go[0] = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c_start[0] === 1'b1) begin ok = 1'b1; break; end
        end
        for (int c = 0; c < 200 && ok; c++) begin
            if (c_start[0] === 1'b0) break;
            @(negedge clk);
        end
        ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            waitc++;
            if (done[0] === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || waitc != 100) begin
            errors++; $display("FAIL timeout_cycles: got %0d WAIT cycles expected 100", waitc);
        end
        checks++;
        if (terr[0] !== 1'b1 || found[0] !== 1'b0) begin
            errors++; $display("FAIL timeout_flag: timeout_err %b found %b expected 1 0", terr[0], found[0]);
        end
        nofin[0] = 1'b0; tgt_en[0] = 1'b1; target[0] = 24'd2;
        go[0] = 1'b1; @(negedge clk); go[0] = 1'b0;
        checks++;
        if (terr[0] !== 1'b0 || c_key[0] !== KS0 || busy[0] !== 1'b1) begin
            errors++; $display("FAIL timeout_restart: timeout_err %b key %h busy %b expected 0 %h 1",
                               terr[0], c_key[0], busy[0], KS0);
        end
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (done[0] === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || found[0] !== 1'b1 || att[0] !== 24'd3) begin
            errors++; $display("FAIL timeout_rerun: found %b attempts %0d expected 1 3", found[0], att[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        tgt_en[0] = 1'b0; lat[0] = 10;
        go[0] = 1'b1; @(negedge clk); go[0] = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c_start[0] === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_wait: LAUNCH never reached"); end
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        checks++;
        if ({c_reset[0], c_start[0], busy[0], done[0], found[0], terr[0]} !== 6'b100000 ||
            c_key[0] !== KS0 || att[0] !== 24'd0 || fkey[0] !== 24'd0) begin
            errors++; $display("FAIL rstmid_values: flags %b key %h attempts %0d found_key %h",
                               {c_reset[0], c_start[0], busy[0], done[0], found[0], terr[0]},
                               c_key[0], att[0], fkey[0]);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0 || c_reset[0] !== 1'b1 || c_start[0] !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle: busy %b done %b core_reset %b core_start %b expected 0 0 1 0",
                               busy[0], done[0], c_reset[0], c_start[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            go[i]   = 1'b0;
            stop[i] = 1'b0;
        end
        test_reset();
        test_found();
        test_exhaust();
        test_overflow();
        test_stop();
        test_stop_check();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
